// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the trap sequencer:
//   - machine-mode CSR addresses touched by the sequencer (mstatus, mepc, mcause)
//   - mstatus bit positions (MIE, MPIE, MPP)
//   - the sequencer state enum
// -----------------------------------------------------------------------------
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SAVE_EPC,
    ST_SAVE_CAUSE,
    ST_RD_STATUS,
    ST_WR_STATUS,
    ST_VECTOR,
    ST_MRET_RD_EPC,
    ST_MRET_RD_STATUS,
    ST_MRET_WR_STATUS,
    ST_REDIRECT
  } trap_state_e;

endpackage

// File: rtl/trap_target_calc.sv
// -----------------------------------------------------------------------------
// trap_target_calc
// Combinational trap-target computation from mtvec.
//   mtvec_i  : mtvec value from the CSR file
//   intr_i   : latched interrupt flag      (only with TRAP_VECTORED_EN)
//   cause_i  : latched exception code      (only with TRAP_VECTORED_EN)
//   target_o : word-aligned redirect target
// Build option: TRAP_VECTORED_EN
//   defined   -> mode 2'b01 with an interrupt jumps to base + cause*4
//   undefined -> mode bits ignored, target is always the base
// -----------------------------------------------------------------------------
module trap_target_calc #(
  parameter int XLEN = 32
`ifdef TRAP_VECTORED_EN
  ,
  parameter int CAUSE_W = 4
`endif
) (
`ifdef TRAP_VECTORED_EN
  input  logic               intr_i,
  input  logic [CAUSE_W-1:0] cause_i,
`endif
  input  logic [XLEN-1:0]    mtvec_i,
  output logic [XLEN-1:0]    target_o
);

  logic [XLEN-1:0] base;

  // Masking (rather than slicing) clears the two mode bits to form the base.
  assign base = mtvec_i & ~XLEN'(3);

`ifdef TRAP_VECTORED_EN
  always_comb begin
    target_o = base;
    if (intr_i && (mtvec_i[1:0] == 2'b01)) begin
      // Wraps modulo 2^XLEN by construction.
      target_o = base + (XLEN'(cause_i) << 2);
    end
  end
`else
  assign target_o = base;
`endif

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Trap sequencer between the pipeline and the machine-mode CSR file. Saves
// mepc/mcause, updates mstatus, reads the trap vector and redirects fetch; on
// mret it restores MIE from MPIE and redirects to mepc.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   exc_valid_i/intr/cause/pc, mret_i
//                         trap and return requests, held until exc_ready_o
//   exc_ready_o, busy_o   handshake (high/low only in IDLE)
//   csr_addr_o/wdata_o/we_o/re_o, csr_except_o, csr_rdata_i
//                         CSR file exception-mode port (read data 1 cycle late)
//   mtvec_i               trap vector base/mode
//   redirect_valid_o/pc_o one-cycle fetch redirect
// Build option: TRAP_VECTORED_EN enables vectored interrupt targets.
// -----------------------------------------------------------------------------
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int CAUSE_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               exc_valid_i,
  input  logic               exc_intr_i,
  input  logic [CAUSE_W-1:0] exc_cause_i,
  input  logic [XLEN-1:0]    exc_pc_i,
  input  logic               mret_i,
  output logic               exc_ready_o,
  output logic [ADDR_W-1:0]  csr_addr_o,
  output logic [XLEN-1:0]    csr_wdata_o,
  output logic               csr_we_o,
  output logic               csr_re_o,
  output logic               csr_except_o,
  input  logic [XLEN-1:0]    csr_rdata_i,
  input  logic [XLEN-1:0]    mtvec_i,
  output logic               redirect_valid_o,
  output logic [XLEN-1:0]    redirect_pc_o,
  output logic               busy_o
);

  trap_state_e state_q, state_d;

  logic               intr_q;
  logic [CAUSE_W-1:0] cause_q;
  logic [XLEN-1:0]    target_q;
  logic [XLEN-1:0]    wdata_q;
  logic [XLEN-1:0]    vec_target;
  logic [XLEN-1:0]    trap_status;
  logic [XLEN-1:0]    mret_status;

  logic [ADDR_W-1:0]  addr_d;
  logic [XLEN-1:0]    wdata_d;
  logic               we_d;
  logic               re_d;

  logic accept_trap;
  assign accept_trap = (state_q == ST_IDLE) && exc_valid_i;

  trap_target_calc #(
    .XLEN    (XLEN)
`ifdef TRAP_VECTORED_EN
    ,
    .CAUSE_W (CAUSE_W)
`endif
  ) u_target_calc (
`ifdef TRAP_VECTORED_EN
    .intr_i   (intr_q),
    .cause_i  (cause_q),
`endif
    .mtvec_i  (mtvec_i),
    .target_o (vec_target)
  );

  // Next state and next CSR-port values. The CSR strobes are decoded from the
  // next state so they leave flops aligned with the state they belong to.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d = state_q;
    addr_d  = '0;
    wdata_d = '0;
    we_d    = 1'b0;
    re_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A trap wins over a simultaneous mret; the mret stays held by its source.
        if (exc_valid_i)  state_d = ST_SAVE_EPC;
        else if (mret_i)  state_d = ST_MRET_RD_EPC;
      end
      ST_SAVE_EPC:       state_d = ST_SAVE_CAUSE;
      ST_SAVE_CAUSE:     state_d = ST_RD_STATUS;
      ST_RD_STATUS:      state_d = ST_WR_STATUS;
      ST_WR_STATUS:      state_d = ST_VECTOR;
      ST_VECTOR:         state_d = ST_REDIRECT;
      ST_MRET_RD_EPC:    state_d = ST_MRET_RD_STATUS;
      ST_MRET_RD_STATUS: state_d = ST_MRET_WR_STATUS;
      ST_MRET_WR_STATUS: state_d = ST_REDIRECT;
      default:           state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_SAVE_EPC: begin
        we_d    = 1'b1;
        addr_d  = ADDR_W'(CSR_MEPC);
        wdata_d = exc_pc_i & ~XLEN'(3);
      end
      ST_SAVE_CAUSE: begin
        we_d    = 1'b1;
        addr_d  = ADDR_W'(CSR_MCAUSE);
        wdata_d = {intr_q, {(XLEN-1-CAUSE_W){1'b0}}, cause_q};
      end
      ST_RD_STATUS, ST_MRET_RD_STATUS: begin
        re_d   = 1'b1;
        addr_d = ADDR_W'(CSR_MSTATUS);
      end
      ST_WR_STATUS, ST_MRET_WR_STATUS: begin
        we_d   = 1'b1;
        addr_d = ADDR_W'(CSR_MSTATUS);
      end
      ST_MRET_RD_EPC: begin
        re_d   = 1'b1;
        addr_d = ADDR_W'(CSR_MEPC);
      end
      default: ;
    endcase
  end

  // mstatus read data arrives in the same cycle the write is issued, so the
  // updated value is formed directly from csr_rdata_i rather than registered.
  always_comb begin
    trap_status                                = csr_rdata_i;
    trap_status[MSTATUS_MPIE]                  = csr_rdata_i[MSTATUS_MIE];
    trap_status[MSTATUS_MIE]                   = 1'b0;
    trap_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    mret_status                = csr_rdata_i;
    mret_status[MSTATUS_MIE]   = csr_rdata_i[MSTATUS_MPIE];
    mret_status[MSTATUS_MPIE]  = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      intr_q     <= 1'b0;
      cause_q    <= '0;
      target_q   <= '0;
      csr_addr_o <= '0;
      wdata_q    <= '0;
      csr_we_o   <= 1'b0;
      csr_re_o   <= 1'b0;
    end else begin
      state_q    <= state_d;
      csr_addr_o <= addr_d;
      wdata_q    <= wdata_d;
      csr_we_o   <= we_d;
      csr_re_o   <= re_d;

      if (accept_trap) begin
        intr_q  <= exc_intr_i;
        cause_q <= exc_cause_i;
      end

      // target_q doubles as the trap vector and the mepc read back on mret.
      if (state_q == ST_VECTOR) begin
        target_q <= vec_target;
      end else if (state_q == ST_MRET_RD_STATUS) begin
        target_q <= csr_rdata_i;
      end
    end
  end

  assign csr_wdata_o = (state_q == ST_WR_STATUS)      ? trap_status :
                       (state_q == ST_MRET_WR_STATUS) ? mret_status :
                                                        wdata_q;

  assign exc_ready_o      = (state_q == ST_IDLE);
  assign busy_o           = ~exc_ready_o;
  assign csr_except_o     = (state_q != ST_IDLE);
  assign redirect_valid_o = (state_q == ST_REDIRECT);
  assign redirect_pc_o    = target_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
// Self-checking bench for trap_ctrl. A small CSR-file stub (registered reads)
// answers the DUT; expected CSR contents, redirect targets and latencies are
// computed from the architectural rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        exc_valid_i;
  logic        exc_intr_i;
  logic [3:0]  exc_cause_i;
  logic [31:0] exc_pc_i;
  logic        mret_i;
  logic        exc_ready_o;
  logic [31:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic        csr_we_o;
  logic        csr_re_o;
  logic        csr_except_o;
  logic [31:0] csr_rdata_i;
  logic [31:0] mtvec_i;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  trap_ctrl #(.XLEN(32), .ADDR_W(32), .CAUSE_W(4)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .exc_valid_i      (exc_valid_i),
    .exc_intr_i       (exc_intr_i),
    .exc_cause_i      (exc_cause_i),
    .exc_pc_i         (exc_pc_i),
    .mret_i           (mret_i),
    .exc_ready_o      (exc_ready_o),
    .csr_addr_o       (csr_addr_o),
    .csr_wdata_o      (csr_wdata_o),
    .csr_we_o         (csr_we_o),
    .csr_re_o         (csr_re_o),
    .csr_except_o     (csr_except_o),
    .csr_rdata_i      (csr_rdata_i),
    .mtvec_i          (mtvec_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .busy_o           (busy_o)
  );

  // ---------------------------------------------------------------------------
  // CSR file stub: writes on the edge, reads registered (one cycle late).
  // ---------------------------------------------------------------------------
  logic [31:0] m_mepc    = '0;
  logic [31:0] m_mcause  = '0;
  logic [31:0] m_mstatus = '0;
  logic [31:0] rdata_q   = '0;
  logic        load      = 1'b0;
  logic [31:0] load_mstatus = '0;
  logic [31:0] load_mepc    = '0;

  always @(posedge clk_i) begin
    if (load) begin
      m_mstatus <= load_mstatus;
      m_mepc    <= load_mepc;
      m_mcause  <= '0;
    end else if (csr_we_o) begin
      case (csr_addr_o)
        32'h341: m_mepc    <= csr_wdata_o;
        32'h342: m_mcause  <= csr_wdata_o;
        32'h300: m_mstatus <= csr_wdata_o;
        default: ;
      endcase
    end
    if (csr_re_o) begin
      case (csr_addr_o)
        32'h341: rdata_q <= m_mepc;
        32'h342: rdata_q <= m_mcause;
        32'h300: rdata_q <= m_mstatus;
        default: rdata_q <= '0;
      endcase
    end
  end
  assign csr_rdata_i = rdata_q;

  // Event counters sampled mid-cycle.
  int wr_cnt    = 0;
  int redir_cnt = 0;
  always @(negedge clk_i) begin
    if (csr_we_o)         wr_cnt    <= wr_cnt + 1;
    if (redirect_valid_o) redir_cnt <= redir_cnt + 1;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (architectural rules)
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ref_target(input logic intr, input logic [3:0] cause,
                                             input logic [31:0] tvec);
    logic [31:0] base;
    logic        vec_build;
    vec_build = 1'b0;
`ifdef TRAP_VECTORED_EN
    vec_build = 1'b1;
`endif
    base = tvec - (tvec % 4);
    if (vec_build && intr && (tvec % 4) == 1) return base + 32'(cause) * 4;
    return base;
  endfunction

  function automatic logic [31:0] ref_trap_status(input logic [31:0] st);
    return (st & ~32'h88) | (((st >> 3) & 32'h1) << 7) | 32'h1800;
  endfunction

  function automatic logic [31:0] ref_mret_status(input logic [31:0] st);
    return (st & ~32'h88) | (((st >> 7) & 32'h1) << 3) | 32'h80;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all drive at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic preload(input logic [31:0] st, input logic [31:0] epc);
    load_mstatus = st;
    load_mepc    = epc;
    load         = 1'b1;
    step();
    load         = 1'b0;
  endtask

  // Called one step after the accept edge; cycle 1 is the current one.
  task automatic wait_redirect(output int lat);
    lat = 0;
    for (int k = 1; k <= 16; k++) begin
      if (redirect_valid_o) begin
        lat = k;
        return;
      end
      step();
    end
  endtask

  task automatic run_trap(input string tag, input logic intr, input logic [3:0] cause,
                          input logic [31:0] pc, input logic [31:0] tvec,
                          input logic [31:0] st);
    int lat, wr0, rd0;
    preload(st, $urandom);
    mtvec_i     = tvec;
    exc_intr_i  = intr;
    exc_cause_i = cause;
    exc_pc_i    = pc;
    exc_valid_i = 1'b1;
    check({tag, "/ready"}, 32'(exc_ready_o), 32'd1);
    wr0 = wr_cnt;
    rd0 = redir_cnt;
    step();
    exc_valid_i = 1'b0;
    exc_intr_i  = ~intr;
    exc_cause_i = 4'($urandom);
    exc_pc_i    = $urandom;
    check({tag, "/busy"}, 32'({busy_o, csr_except_o}), 32'd3);
    wait_redirect(lat);
    check({tag, "/latency"}, 32'(lat), 32'd6);
    check({tag, "/target"}, redirect_pc_o, ref_target(intr, cause, tvec));
    step();
    check({tag, "/pulse"}, 32'({redirect_valid_o, exc_ready_o}), 32'd1);
    check({tag, "/mepc"}, m_mepc, pc - (pc % 4));
    check({tag, "/mcause"}, m_mcause, (intr ? 32'h8000_0000 : 32'h0) | 32'(cause));
    check({tag, "/mstatus"}, m_mstatus, ref_trap_status(st));
    check({tag, "/writes"}, 32'(wr_cnt - wr0), 32'd3);
    check({tag, "/redirects"}, 32'(redir_cnt - rd0), 32'd1);
  endtask

  task automatic run_mret(input string tag, input logic [31:0] epc, input logic [31:0] st);
    int lat, wr0, rd0;
    preload(st, epc);
    mret_i = 1'b1;
    check({tag, "/ready"}, 32'(exc_ready_o), 32'd1);
    wr0 = wr_cnt;
    rd0 = redir_cnt;
    step();
    mret_i = 1'b0;
    wait_redirect(lat);
    check({tag, "/latency"}, 32'(lat), 32'd4);
    check({tag, "/target"}, redirect_pc_o, epc);
    step();
    check({tag, "/pulse"}, 32'({redirect_valid_o, exc_ready_o}), 32'd1);
    check({tag, "/mstatus"}, m_mstatus, ref_mret_status(st));
    check({tag, "/mepc"}, m_mepc, epc);
    check({tag, "/writes"}, 32'(wr_cnt - wr0), 32'd1);
    check({tag, "/redirects"}, 32'(redir_cnt - rd0), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int lat, wr0, rd0;
    rst_i       = 1'b1;
    exc_valid_i = 1'b0;
    exc_intr_i  = 1'b0;
    exc_cause_i = '0;
    exc_pc_i    = '0;
    mret_i      = 1'b0;
    mtvec_i     = '0;
    repeat (3) step();

    // Reset state
    check("rst/ready", 32'(exc_ready_o), 32'd1);
    check("rst/strobes", 32'({busy_o, csr_we_o, csr_re_o, csr_except_o, redirect_valid_o}), 32'd0);
    check("rst/addr", csr_addr_o, 32'd0);
    check("rst/wdata", csr_wdata_o, 32'd0);
    check("rst/pc", redirect_pc_o, 32'd0);
    rst_i = 1'b0;
    step();

    // Directed: basic exception, vectored-mode interrupt, mret
    run_trap("t1", 1'b0, 4'd2, 32'h1002, 32'h8000, 32'h8);
    run_trap("t2", 1'b1, 4'd7, 32'h2000, 32'h8001, 32'h0);
    run_trap("t2x", 1'b0, 4'd7, 32'h2000, 32'h8001, 32'h0);
    run_mret("t3", 32'h1000, 32'h80);
    run_trap("wrap", 1'b1, 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'hFFFF_FFFF);

    // Simultaneous trap and mret: trap first, held mret after return to IDLE
    preload(32'h8, 32'h5555);
    mtvec_i     = 32'h4000;
    exc_intr_i  = 1'b0;
    exc_cause_i = 4'd3;
    exc_pc_i    = 32'h2004;
    exc_valid_i = 1'b1;
    mret_i      = 1'b1;
    step();
    exc_valid_i = 1'b0;
    wait_redirect(lat);
    check("t4/trap_latency", 32'(lat), 32'd6);
    check("t4/trap_target", redirect_pc_o, 32'h4000);
    step();
    check("t4/ready_again", 32'(exc_ready_o), 32'd1);
    check("t4/trap_status", m_mstatus, 32'h1880);
    step();
    mret_i = 1'b0;
    wait_redirect(lat);
    check("t4/mret_latency", 32'(lat), 32'd4);
    check("t4/mret_target", redirect_pc_o, 32'h2004);
    step();
    check("t4/mret_status", m_mstatus, 32'h1888);

    // Requests pulsed while busy are ignored
    preload(32'h0, 32'h0);
    mtvec_i     = 32'h9000;
    exc_intr_i  = 1'b0;
    exc_cause_i = 4'd5;
    exc_pc_i    = 32'h3000;
    exc_valid_i = 1'b1;
    wr0 = wr_cnt;
    rd0 = redir_cnt;
    step();
    exc_valid_i = 1'b0;
    step();
    exc_valid_i = 1'b1;
    mret_i      = 1'b1;
    exc_pc_i    = 32'h7777;
    check("t5/not_ready", 32'(exc_ready_o), 32'd0);
    step();
    exc_valid_i = 1'b0;
    mret_i      = 1'b0;
    wait_redirect(lat);
    check("t5/latency", 32'(lat), 32'd4);
    check("t5/target", redirect_pc_o, 32'h9000);
    repeat (4) step();
    check("t5/writes", 32'(wr_cnt - wr0), 32'd3);
    check("t5/redirects", 32'(redir_cnt - rd0), 32'd1);
    check("t5/mepc", m_mepc, 32'h3000);

    // Reset while in RD_STATUS
    preload(32'h8, 32'h0);
    mtvec_i     = 32'h8000;
    exc_pc_i    = 32'h1234;
    exc_valid_i = 1'b1;
    wr0 = wr_cnt;
    rd0 = redir_cnt;
    step();
    exc_valid_i = 1'b0;
    step();
    step();
    check("t6/in_rd_status", 32'({csr_re_o, csr_addr_o[11:0]}), 32'h1300);
    rst_i = 1'b1;
    step();
    check("t6/ready", 32'(exc_ready_o), 32'd1);
    check("t6/strobes", 32'({busy_o, csr_we_o, csr_re_o, csr_except_o, redirect_valid_o}), 32'd0);
    check("t6/addr", csr_addr_o, 32'd0);
    rst_i = 1'b0;
    repeat (8) step();
    check("t6/mstatus", m_mstatus, 32'h8);
    check("t6/mepc", m_mepc, 32'h1234);
    check("t6/writes", 32'(wr_cnt - wr0), 32'd2);
    check("t6/redirects", 32'(redir_cnt - rd0), 32'd0);

    // Randomized mix of traps and returns
    for (int i = 0; i < 40; i++) begin
      logic [31:0] tvec;
      tvec = $urandom;
      if ($urandom_range(1, 0) == 1) tvec = (tvec & ~32'h3) | 32'h1;
      if ($urandom_range(2, 0) == 0)
        run_mret($sformatf("rnd%0d", i), $urandom, $urandom);
      else
        run_trap($sformatf("rnd%0d", i), 1'($urandom), 4'($urandom), $urandom, tvec, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
